// File: rtl/muldiv_ctrl_if.sv
// Request/response bus between the control FSM and the Hi/Lo mult/div sequencer.
interface muldiv_ctrl_if;
  logic        start;
  logic        op;        // 0 = MULT, 1 = DIV (both signed)
  logic [31:0] a_in;
  logic [31:0] b_in;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;
  logic        div_zero;

  // control unit side
  modport master (output start, op, a_in, b_in,
                  input  hi, lo, busy, done, div_zero);
  // sequencer side
  modport slave  (input  start, op, a_in, b_in,
                  output hi, lo, busy, done, div_zero);
endinterface

// File: rtl/muldiv_ctrl.sv
// Sequencer for the multicycle multiply/divide units feeding Hi/Lo.
// Freezes operands, pulses a one-cycle load into the selected unit, waits
// out its iteration count, then captures the result into Hi/Lo.
module muldiv_ctrl #(
  parameter int MULT_CYCLES = 32,
  parameter int DIV_CYCLES  = 32,
  parameter int CNT_W       = 6
) (
  input  logic              clk,
  input  logic              reset,
  muldiv_ctrl_if.slave      bus,
  output logic [31:0]       op_a,
  output logic [31:0]       op_b,
  output logic              mult_load,
  output logic              div_load,
  input  logic [31:0]       mult_hi,
  input  logic [31:0]       mult_lo,
  input  logic [31:0]       div_hi,
  input  logic [31:0]       div_lo
);

  typedef enum logic [2:0] {IDLE, LOAD, RUN, CAPTURE, DONE} state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic               op_q;      // latched op: 1 = DIV
  logic               dz_q;      // current request took the zero-divisor path
  logic [31:0]        hi_q, lo_q;
  logic               accept;
  logic               zero_div;

  // A new request is only taken when nothing is in flight; DONE counts as free
  // so a launch can overlap the Hi/Lo read of the previous result.
  assign accept   = bus.start && (state == IDLE || state == DONE);
  assign zero_div = bus.op && (bus.b_in == 32'd0);

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state and state-decoded outputs
  always_comb begin
    state_nxt    = state;
    mult_load    = 1'b0;
    div_load     = 1'b0;
    bus.busy     = 1'b0;
    bus.done     = 1'b0;
    bus.div_zero = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) state_nxt = zero_div ? DONE : LOAD;
      end
      LOAD: begin
        mult_load = ~op_q;
        div_load  = op_q;
        bus.busy  = 1'b1;
        state_nxt = RUN;
      end
      RUN: begin
        bus.busy = 1'b1;
        if (cnt == CNT_W'(1)) state_nxt = CAPTURE;
      end
      CAPTURE: begin
        bus.busy  = 1'b1;
        state_nxt = DONE;
      end
      DONE: begin
        bus.done     = 1'b1;
        bus.div_zero = dz_q;
        if (bus.start) state_nxt = zero_div ? DONE : LOAD;
        else           state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand freeze, iteration counter and Hi/Lo capture
  always_ff @(posedge clk) begin
    if (reset) begin
      op_a <= '0;
      op_b <= '0;
      op_q <= 1'b0;
      dz_q <= 1'b0;
      cnt  <= '0;
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      if (accept) begin
        op_a <= bus.a_in;
        op_b <= bus.b_in;
        op_q <= bus.op;
        dz_q <= zero_div;
      end
      case (state)
        LOAD:    cnt <= op_q ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
        RUN:     cnt <= cnt - CNT_W'(1);
        CAPTURE: begin
          hi_q <= op_q ? div_hi : mult_hi;
          lo_q <= op_q ? div_lo : mult_lo;
        end
        default: ;
      endcase
    end
  end

  assign bus.hi = hi_q;
  assign bus.lo = lo_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl with a behavioural mult/div datapath.
module tb_muldiv_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] op_a, op_b;
  logic        mult_load, div_load;
  logic [31:0] mult_hi, mult_lo, div_hi, div_lo;

  muldiv_ctrl_if bus();

  muldiv_ctrl #(.MULT_CYCLES(32), .DIV_CYCLES(32), .CNT_W(6)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus.slave),
    .op_a     (op_a),
    .op_b     (op_b),
    .mult_load(mult_load),
    .div_load (div_load),
    .mult_hi  (mult_hi),
    .mult_lo  (mult_lo),
    .div_hi   (div_hi),
    .div_lo   (div_lo)
  );

  always #5 clk = ~clk;

  // Behavioural units: results follow the frozen operands
  logic [63:0] prod;
  always_comb begin
    prod    = {{32{op_a[31]}}, op_a} * {{32{op_b[31]}}, op_b};
    mult_hi = prod[63:32];
    mult_lo = prod[31:0];
    if (op_b == 32'd0) begin
      div_lo = 32'd0;
      div_hi = 32'd0;
    end else begin
      div_lo = $signed(op_a) / $signed(op_b);
      div_hi = $signed(op_a) % $signed(op_b);
    end
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)", tag, got, got, exp, exp);
  endtask

  task automatic go(input logic op, input logic [31:0] a, input logic [31:0] b);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a_in  = a;
    bus.b_in  = b;
  endtask

  // Called at the negedge of cycle 0 with start already driven. Steps cycles,
  // tallying load pulses and busy, until done or the budget runs out.
  // p1/p2: cycles in which a junk start is pulsed; rc: cycle in which reset is held.
  task automatic run(input int p1, input int p2, input int rc,
                     output int cyc, output int ml, output int dl, output int bz,
                     output logic dz);
    cyc = -1; ml = 0; dl = 0; bz = 0; dz = 1'b0;
    for (int c = 1; c <= 60 && cyc < 0; c++) begin
      @(negedge clk);
      if (rc > 0 && c == rc + 1) begin
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_hi",   bus.hi, 32'd0);
        chk("rst_lo",   bus.lo, 32'd0);
        chk("rst_load", 32'(mult_load), 32'd0);
        reset = 1'b0;
      end
      ml += int'(mult_load);
      dl += int'(div_load);
      bz += int'(bus.busy);
      if (bus.done) begin
        cyc = c;
        dz  = bus.div_zero;
        bus.start = 1'b0;
      end else begin
        bus.start = (c == p1 || c == p2);
        if (bus.start) begin
          bus.op   = 1'b1;
          bus.a_in = 32'hDEAD_0009;
          bus.b_in = 32'd0;
        end
        if (c == rc) reset = 1'b1;
      end
    end
  endtask

  int   cyc, ml, dl, bz;
  logic dz;

  initial begin
    reset = 1'b1;
    bus.start = 1'b0; bus.op = 1'b0; bus.a_in = '0; bus.b_in = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy0", 32'(bus.busy), 32'd0);
    chk("rst_done0", 32'(bus.done), 32'd0);
    chk("rst_hilo0", bus.hi | bus.lo, 32'd0);
    chk("rst_opa0",  op_a, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // MULT 7 * -3
    go(1'b0, 32'd7, 32'hFFFF_FFFD);
    run(0, 0, 0, cyc, ml, dl, bz, dz);
    chk("m1_cyc", cyc, 32'd35);
    chk("m1_ml",  ml,  32'd1);
    chk("m1_dl",  dl,  32'd0);
    chk("m1_busy", bz, 32'd34);
    chk("m1_hi",  bus.hi, 32'hFFFF_FFFF);
    chk("m1_lo",  bus.lo, 32'hFFFF_FFEB);
    chk("m1_dz",  32'(dz), 32'd0);
    @(negedge clk);
    chk("m1_done_once", 32'(bus.done), 32'd0);
    chk("m1_idle_busy", 32'(bus.busy), 32'd0);

    // DIV 100 / 7
    go(1'b1, 32'd100, 32'd7);
    run(0, 0, 0, cyc, ml, dl, bz, dz);
    chk("d1_cyc", cyc, 32'd35);
    chk("d1_dl",  dl,  32'd1);
    chk("d1_ml",  ml,  32'd0);
    chk("d1_lo",  bus.lo, 32'd14);
    chk("d1_hi",  bus.hi, 32'd2);
    chk("d1_dz",  32'(dz), 32'd0);
    @(negedge clk);

    // Preload hi/lo = 0x1234/0x5678 through a real divide
    go(1'b1, 32'h5678_1234, 32'h0001_0000);
    run(0, 0, 0, cyc, ml, dl, bz, dz);
    chk("pre_hi", bus.hi, 32'h0000_1234);
    chk("pre_lo", bus.lo, 32'h0000_5678);
    @(negedge clk);

    // DIV 5 / 0: immediate done + div_zero, no launch, hi/lo untouched
    go(1'b1, 32'd5, 32'd0);
    run(0, 0, 0, cyc, ml, dl, bz, dz);
    chk("dz_cyc",  cyc, 32'd1);
    chk("dz_flag", 32'(dz), 32'd1);
    chk("dz_loads", ml + dl, 32'd0);
    chk("dz_busy", bz, 32'd0);
    chk("dz_hi",   bus.hi, 32'h0000_1234);
    chk("dz_lo",   bus.lo, 32'h0000_5678);
    chk("dz_opa",  op_a, 32'd5);
    @(negedge clk);
    chk("dz_clear", 32'(bus.div_zero), 32'd0);

    // MULT 0x100 * 0x100 with junk starts at cycles 5 and 20
    go(1'b0, 32'h100, 32'h100);
    run(5, 20, 0, cyc, ml, dl, bz, dz);
    chk("ign_cyc", cyc, 32'd35);
    chk("ign_opa", op_a, 32'h100);
    chk("ign_opb", op_b, 32'h100);
    chk("ign_hi",  bus.hi, 32'd0);
    chk("ign_lo",  bus.lo, 32'h0001_0000);
    chk("ign_dz",  32'(dz), 32'd0);
    chk("ign_dl",  dl, 32'd0);
    @(negedge clk);
    chk("ign_done_once", 32'(bus.done), 32'd0);

    // MULT 5 * 6 aborted by reset in cycle 10: no done within budget
    go(1'b0, 32'd5, 32'd6);
    run(0, 0, 10, cyc, ml, dl, bz, dz);
    chk("abort_nodone", cyc, 32'hFFFF_FFFF);
    chk("abort_ml", ml, 32'd1);

    // Fresh MULT -2 * -3 after the abort
    go(1'b0, 32'hFFFF_FFFE, 32'hFFFF_FFFD);
    run(0, 0, 0, cyc, ml, dl, bz, dz);
    chk("fresh_cyc", cyc, 32'd35);
    chk("fresh_lo",  bus.lo, 32'd6);
    chk("fresh_hi",  bus.hi, 32'd0);
    @(negedge clk);

    // Back-to-back: MULT 3*4, then DIV 9/2 launched in its DONE cycle
    go(1'b0, 32'd3, 32'd4);
    run(0, 0, 0, cyc, ml, dl, bz, dz);
    chk("b2b_m_cyc", cyc, 32'd35);
    chk("b2b_m_lo",  bus.lo, 32'd12);
    go(1'b1, 32'd9, 32'd2);
    run(0, 0, 0, cyc, ml, dl, bz, dz);
    chk("b2b_d_cyc", cyc, 32'd35);
    chk("b2b_d_dl",  dl, 32'd1);
    chk("b2b_d_lo",  bus.lo, 32'd4);
    chk("b2b_d_hi",  bus.hi, 32'd1);
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
